// File: rtl/keycode_fifo_pio.sv
// Keycode FIFO PIO: the CPU pushes keycodes over Avalon-MM and the synth drains them as a valid/ready stream.
// Define KEYCODE_FIFO_LOWWATER_IRQ_EN to add the THRESHOLD register at addr 3 and the low-water interrupt.
module keycode_fifo_pio #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;

    logic wr_hit, push_req, push_acc, pop, flush, full, empty;

    assign wr_hit    = chipselect & ~write_n;
    assign push_req  = wr_hit & (address == 2'd0);
    assign full      = (level_q == CNT_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push_acc  = push_req & (~full | pop);
    assign flush     = wr_hit & (address == 2'd2) & writedata[1];
    // Gated so out_data reads 0 out of reset even though the storage is never cleared.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign irq       = irq_q;

`ifdef KEYCODE_FIFO_LOWWATER_IRQ_EN
    logic [CNT_W-1:0] threshold_q, threshold_d;
    logic             lw_armed_q, lw_armed_d;
    logic             thr_wr;

    assign thr_wr = wr_hit & (address == 2'd3);

    always_comb begin
        threshold_d = thr_wr ? writedata[CNT_W-1:0] : threshold_q;
        // A threshold write or flush disarms; re-arming needs the level to climb above threshold again.
        lw_armed_d  = (thr_wr | flush) ? 1'b0 : (lw_armed_q | (level_q > threshold_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold_q <= '0;
            lw_armed_q  <= 1'b0;
        end else begin
            threshold_q <= threshold_d;
            lw_armed_q  <= lw_armed_d;
        end
    end

    assign irq_d = irq_en_q & (overflow_q | ((level_q <= threshold_q) & lw_armed_q));
`else
    assign irq_d = irq_en_q & overflow_q;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        irq_en_d    = irq_en_q;
        last_data_d = last_data_q;

        if (push_req) last_data_d = writedata[DATA_W-1:0];
        if (push_req & ~push_acc) overflow_d = 1'b1;
        if (wr_hit & (address == 2'd1) & writedata[18]) overflow_d = 1'b0;
        if (wr_hit & (address == 2'd2)) irq_en_d = writedata[0];

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_acc & ~pop)      level_d = level_q + 1'b1;
            else if (pop & ~push_acc) level_d = level_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            last_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            last_data_q <= last_data_d;
        end
    end

    // NOTE: the storage array has no reset; level and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = 32'(last_data_q);
            2'd1: begin
                readdata[CNT_W-1:0] = level_q;
                readdata[16]        = empty;
                readdata[17]        = full;
                readdata[18]        = overflow_q;
            end
            2'd2: readdata[0] = irq_en_q;
`ifdef KEYCODE_FIFO_LOWWATER_IRQ_EN
            2'd3: readdata = 32'(threshold_q);
`endif
            default: readdata = '0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^writedata;
endmodule

// File: doc/keycode_fifo_pio.md
Name: keycode_fifo_pio

Overview:
Parametrised successor to the single-register keycode PIO. The CPU (Avalon-MM slave, zero-wait-state) writes keycodes into a DEPTH-entry FIFO rather than overwriting one register, so bursts of USB HID key events are not lost. The audio/synth logic drains events through a valid/ready stream. The block adds status readback, a sticky overflow flag, a flush control and an interrupt line.

Parameters:
DATA_W, 32, keycode/event width; 1..32; writedata[DATA_W-1:0] is used.
DEPTH, 16, FIFO entries; power of 2, 2..256.
CNT_W, log2(DEPTH)+1, derived level-counter width; not overridable.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational from address
out_data  out  DATA_W  head-of-FIFO keycode
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
irq  out  1  level interrupt to CPU

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock. Reset clears pointers, level, overflow, irq_en, last_data (and threshold, if present) to 0. Outputs: out_valid=0, irq=0, out_data=0. FIFO storage is not required to be cleared.
- wr_hit = chipselect & ~write_n; push_req = wr_hit & (address==0); pop = out_valid & out_ready.
- Register map (readdata unused bits read 0):
  - addr 0 DATA
    - write: push_req.
    - read: last_data, i.e. the last value written to addr 0, captured whether or not the push was accepted (legacy-compatible).
  - addr 1 STATUS
    - [CNT_W-1:0] level; [16] empty; [17] full; [18] overflow (sticky).
    - A write with writedata[18]=1 clears overflow.
  - addr 2 CONTROL
    - [0] irq_en, read/write.
    - [1] flush: write-1 pulse, not stored, reads 0.
  - addr 3: see Optional Feature; reads 0 when the feature is compiled out.
- Push accept = push_req & (~full | pop). A push when full with no same-cycle pop is dropped, sets overflow, and leaves FIFO contents and level unchanged.
- Entry written at edge N: out_valid=1 and out_data valid from cycle N+1 (1-cycle latency). There is no bypass when empty.
- out_data = mem[rd_ptr], combinational from the registered pointer. It is held stable while out_valid=1 and out_ready=0.
- Level update: +1 on accepted push only, -1 on pop only, unchanged on both. Pointers wrap modulo DEPTH. full = (level==DEPTH); empty = (level==0).
- Flush (wr_hit, addr 2, writedata[1]=1): pointers and level go to 0 at the next edge and override any same-cycle pop. Overflow, irq_en and last_data are unaffected. out_valid is 0 from the next cycle.
- Overflow set and clear in the same cycle cannot occur (one bus op per cycle). A pop never clears overflow.
- irq (registered, asserts 1 cycle after its condition) = irq_en & overflow. Without the feature there are no other sources.
- Reset asserted mid-operation discards all queued entries immediately. out_valid falls asynchronously.

Optional Feature:
KEYCODE_FIFO_LOWWATER_IRQ_EN
- Defined:
  - addr 3 is a read/write THRESHOLD register, [CNT_W-1:0], reset 0.
  - irq = irq_en & (overflow | (level <= THRESHOLD & lw_armed)).
  - lw_armed sets when level exceeds THRESHOLD. It clears when the CPU writes THRESHOLD or when a flush occurs.
  - Purpose: the CPU refills the FIFO before the synth starves.
- Undefined:
  - addr 3 reads 0 and writes are ignored.
  - irq = irq_en & overflow.
  - No extra registers are synthesised.

Test Plan:
- Reset then idle → readdata 0 at all addresses except STATUS = 0x0001_0000 (empty); out_valid=0; irq=0.
- Write 0x1A, 0x2B, 0x3C to addr 0 with out_ready=0 → STATUS level=3; out_data=0x1A; raise out_ready for 3 cycles → 0x1A, 0x2B, 0x3C in order, then out_valid=0 and level=0.
- DEPTH=16, out_ready=0: 17 writes (0x00..0x10) → full=1, overflow=1, level=16; addr 0 reads 0x10; the drain yields 0x00..0x0F only.
- While full, write 0x55 in the same cycle as a pop → push accepted, level stays 16, no new overflow; 0x55 emerges last.
- Set irq_en, force overflow → irq=1 one cycle later; write STATUS bit18=1 → overflow=0, irq=0 next cycle; write CONTROL=0x3 with 5 entries queued → level 0, out_valid=0, irq_en stays 1.
- With KEYCODE_FIFO_LOWWATER_IRQ_EN, THRESHOLD=2, irq_en=1: push 4, then drain 2 → irq rises when level reaches 2; write THRESHOLD=2 → irq falls (disarmed).
